// File: rtl/testbasic07_source.sv
// Burst source: accepts a {start, step, count} config word, then streams an arithmetic
// sequence over a valid/ready port and reports the number of words sent.
module testbasic07_source #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [31:0]      cfg_start,
  input  logic signed [31:0]      cfg_step,
  input  logic        [CNT_W-1:0] cfg_count,
  input  logic                    cfg_sync,
  output logic                    cfg_notify,
  output logic signed [31:0]      b_out,
  output logic                    b_out_notify,
  input  logic                    b_out_sync,
  output logic        [31:0]      m_out,
  output logic                    m_out_notify
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  value_q, value_d;
  logic signed [DATA_W-1:0]  step_q, step_d;
  logic        [CNT_W-1:0]   remaining_q, remaining_d;
  logic        [CNT_W-1:0]   sent_q, sent_d;
  logic        [DATA_W-1:0]  m_out_q, m_out_d;
  logic        [CNT_W-1:0]   sent_inc;

  // Plain two's-complement wrap: the sum is simply truncated to DATA_W bits.
  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  function automatic logic [DATA_W-1:0] zext(input logic [CNT_W-1:0] x);
    return DATA_W'(x);
  endfunction

  assign sent_inc = sent_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    m_out_d     = m_out_q;
    case (state_q)
      IDLE: begin
        if (cfg_sync) begin
          value_d     = cfg_start;
          step_d      = cfg_step;
          remaining_d = cfg_count;
          sent_d      = '0;
          if (cfg_count == '0) begin
            state_d = DONE;
            m_out_d = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (b_out_sync) begin
          value_d     = wrap_add(value_q, step_q);
          remaining_d = remaining_q - CNT_W'(1);
          sent_d      = sent_inc;
          // m_out is loaded on the way into DONE so it is already valid with the strobe.
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
            m_out_d = zext(sent_inc);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      value_q     <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
      m_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      m_out_q     <= m_out_d;
    end
  end

  assign cfg_notify   = (state_q == IDLE);
  assign b_out_notify = (state_q == RUN);
  assign m_out_notify = (state_q == DONE);
  assign b_out        = value_q;
  assign m_out        = m_out_q;

endmodule

// File: tb/tb_testbasic07_source.sv
// Directed bench for testbasic07_source: hand-computed bursts, stalls, wrap, empty burst
// and mid-burst reset.
module tb_testbasic07_source;

  localparam int CNT_W = 16;

  logic                    clk;
  logic                    rst;
  logic signed [31:0]      cfg_start;
  logic signed [31:0]      cfg_step;
  logic        [CNT_W-1:0] cfg_count;
  logic                    cfg_sync;
  logic                    cfg_notify;
  logic signed [31:0]      b_out;
  logic                    b_out_notify;
  logic                    b_out_sync;
  logic        [31:0]      m_out;
  logic                    m_out_notify;

  int n_checks = 0;
  int n_fail   = 0;

  testbasic07_source #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_step     (cfg_step),
    .cfg_count    (cfg_count),
    .cfg_sync     (cfg_sync),
    .cfg_notify   (cfg_notify),
    .b_out        (b_out),
    .b_out_notify (b_out_notify),
    .b_out_sync   (b_out_sync),
    .m_out        (m_out),
    .m_out_notify (m_out_notify)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic signed [31:0] s, input logic signed [31:0] st,
                          input logic [CNT_W-1:0] c);
    cfg_start = s;
    cfg_step  = st;
    cfg_count = c;
    cfg_sync  = 1'b1;
    tick();
    cfg_sync  = 1'b0;
  endtask

  logic [31:0] exp_t2 [6];
  logic        sync_t2 [6];

  initial begin
    rst        = 1'b0;
    cfg_start  = '0;
    cfg_step   = '0;
    cfg_count  = '0;
    cfg_sync   = 1'b0;
    b_out_sync = 1'b0;
    exp_t2  = '{32'd5, 32'd6, 32'd6, 32'd6, 32'd7, 32'd7};
    sync_t2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    #12;
    chk("rst_cfg_notify", {31'd0, cfg_notify}, 32'd1);
    chk("rst_b_notify", {31'd0, b_out_notify}, 32'd0);
    chk("rst_m_notify", {31'd0, m_out_notify}, 32'd0);
    chk("rst_b_out", b_out, 32'd0);
    chk("rst_m_out", m_out, 32'd0);
    tick();
    rst = 1'b1;

    // Burst 10,13,16,19 with the consumer always ready.
    b_out_sync = 1'b1;
    send_cfg(32'sd10, 32'sd3, 16'd4);
    chk("t1_cfg_notify_low", {31'd0, cfg_notify}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_b_notify", {31'd0, b_out_notify}, 32'd1);
      chk("t1_b_out", b_out, 32'(10 + 3 * i));
      tick();
    end
    chk("t1_b_notify_done", {31'd0, b_out_notify}, 32'd0);
    chk("t1_m_notify", {31'd0, m_out_notify}, 32'd1);
    chk("t1_m_out", m_out, 32'd4);
    tick();
    chk("t1_m_notify_off", {31'd0, m_out_notify}, 32'd0);
    chk("t1_cfg_notify", {31'd0, cfg_notify}, 32'd1);
    chk("t1_m_out_hold", m_out, 32'd4);
    tick();
    chk("t1_m_out_hold2", m_out, 32'd4);

    // Stalling consumer: 5, then 6 held over two stalls, then 7.
    b_out_sync = 1'b0;
    send_cfg(32'sd5, 32'sd1, 16'd3);
    for (int i = 0; i < 6; i++) begin
      b_out_sync = sync_t2[i];
      chk("t2_b_notify", {31'd0, b_out_notify}, 32'd1);
      chk("t2_b_out", b_out, exp_t2[i]);
      tick();
    end
    b_out_sync = 1'b0;
    chk("t2_m_notify", {31'd0, m_out_notify}, 32'd1);
    chk("t2_m_out", m_out, 32'd3);
    tick();
    chk("t2_cfg_notify", {31'd0, cfg_notify}, 32'd1);

    // Positive wrap; a cfg_sync during RUN must be ignored.
    b_out_sync = 1'b1;
    send_cfg(32'sh7FFFFFFF, 32'sd1, 16'd2);
    cfg_start = 32'sd99;
    cfg_count = 16'd9;
    cfg_sync  = 1'b1;
    chk("t3_b_out0", b_out, 32'h7FFFFFFF);
    tick();
    chk("t3_b_out1", b_out, 32'h80000000);
    tick();
    cfg_sync = 1'b0;
    chk("t3_m_out", m_out, 32'd2);
    chk("t3_m_notify", {31'd0, m_out_notify}, 32'd1);
    tick();

    // Negative step.
    send_cfg(-32'sd2, -32'sd1, 16'd2);
    chk("t3_neg0", b_out, 32'hFFFFFFFE);
    tick();
    chk("t3_neg1", b_out, 32'hFFFFFFFD);
    tick();
    chk("t3_neg_m_out", m_out, 32'd2);
    tick();

    // Empty burst.
    send_cfg(32'sd50, 32'sd1, 16'd0);
    chk("t4_b_notify", {31'd0, b_out_notify}, 32'd0);
    chk("t4_m_notify", {31'd0, m_out_notify}, 32'd1);
    chk("t4_m_out", m_out, 32'd0);
    tick();
    chk("t4_cfg_notify", {31'd0, cfg_notify}, 32'd1);
    chk("t4_m_notify_off", {31'd0, m_out_notify}, 32'd0);

    // Reset after the second of five transfers.
    send_cfg(32'sd100, 32'sd1, 16'd5);
    tick();
    tick();
    chk("t5_b_out_pre", b_out, 32'd102);
    rst = 1'b0;
    #2;
    chk("t5_cfg_notify", {31'd0, cfg_notify}, 32'd1);
    chk("t5_b_notify", {31'd0, b_out_notify}, 32'd0);
    chk("t5_m_notify", {31'd0, m_out_notify}, 32'd0);
    chk("t5_b_out", b_out, 32'd0);
    chk("t5_m_out", m_out, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_m_notify", {31'd0, m_out_notify}, 32'd0);
      tick();
    end
    send_cfg(32'sd7, 32'sd2, 16'd1);
    chk("t5_new_b_notify", {31'd0, b_out_notify}, 32'd1);
    chk("t5_new_b_out", b_out, 32'd7);
    tick();
    chk("t5_new_m_notify", {31'd0, m_out_notify}, 32'd1);
    chk("t5_new_m_out", m_out, 32'd1);
    tick();
    chk("t5_idle", {31'd0, cfg_notify}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/testbasic07_source.md
TESTBASIC07_SOURCE -- requirements
Module: testbasic07_source

Interface
REQ-001 Parameter CNT_W, default 16: width of the burst-length field and internal remaining counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 cfg_start  input  32 (integer)  first value of burst, signed.
REQ-006 cfg_step  input  32 (integer)  increment between values, signed.
REQ-007 cfg_count  input  CNT_W  number of words in burst, unsigned.
REQ-008 cfg_sync  input  1  config word valid (blocking-in handshake).
REQ-009 cfg_notify  output  1  block ready to accept config.
REQ-010 b_out  output  32 (integer)  data word toward testbasic07 b_in.
REQ-011 b_out_notify  output  1  b_out valid; drives consumer b_in_sync.
REQ-012 b_out_sync  input  1  consumer ready; driven by consumer b_in_notify.
REQ-013 m_out  output  32 (integer)  number of words sent in last burst.
REQ-014 m_out_notify  output  1  one-cycle strobe, m_out updated.

Function
REQ-015 A transfer SHALL occur on a rising clk edge where both notify and sync of the same port are high; no other edge transfers.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; only IDLE asserts cfg_notify, only RUN asserts b_out_notify, only DONE asserts m_out_notify.
REQ-017 IDLE: cfg transfer SHALL capture cfg_start, cfg_step, cfg_count; count=0 -> DONE, else -> RUN with value=cfg_start, remaining=cfg_count, sent=0.
REQ-018 IDLE without cfg_sync: remain IDLE, cfg inputs ignored.
REQ-019 RUN: b_out SHALL equal current value; b_out and b_out_notify SHALL stay stable while b_out_sync is low (no retraction, no change).
REQ-020 RUN transfer: value <= value + step (32-bit two's-complement wrap, no saturation), remaining <= remaining-1, sent <= sent+1.
REQ-021 RUN transfer with remaining=1 SHALL go to DONE the next cycle; b_out_notify low in DONE.
REQ-022 Back-to-back transfers SHALL be supported: one word per cycle while b_out_sync held high.
REQ-023 DONE: m_out SHALL equal sent (zero-extended to 32 bits), m_out_notify high exactly one cycle, then IDLE.
REQ-024 m_out SHALL hold its value after DONE until the next DONE.
REQ-025 cfg_count = 2^CNT_W-1 SHALL produce exactly that many words; counter never wraps.
REQ-026 Latency: cfg transfer edge -> b_out_notify high next cycle; last data transfer edge -> m_out_notify high next cycle; DONE -> cfg_notify high next cycle.
REQ-027 cfg_sync and b_out_sync asserted simultaneously SHALL be handled per current state only; the inactive port's sync is ignored.

Reset
REQ-028 rst low SHALL force, asynchronously, state=IDLE, cfg_notify=1, b_out_notify=0, m_out_notify=0, b_out=0, m_out=0, value/remaining/sent=0.
REQ-029 rst low mid-burst SHALL abort the burst; no m_out_notify for the aborted burst; after release block is in IDLE accepting config.
REQ-030 First config SHALL be accepted on the first rising edge after rst deasserts with cfg_sync high.

Verification
REQ-031 start=10, step=3, count=4, b_out_sync held 1 -> b_out 10,13,16,19 on four consecutive cycles, then m_out=4 with m_out_notify one cycle, cfg_notify back to 1.
REQ-032 start=5, step=1, count=3, b_out_sync toggled 1,0,0,1,0,1 -> b_out holds 6 across stall cycles with notify high; exactly 3 transfers; m_out=3.
REQ-033 start=0x7FFFFFFF, step=1, count=2 -> b_out 0x7FFFFFFF then 0x80000000; start=-2, step=-1, count=2 -> b_out -2, -3.
REQ-034 count=0 -> no b_out_notify, m_out_notify next cycle with m_out=0, then IDLE.
REQ-035 rst pulsed low after second of count=5 transfers -> all notifies 0 except cfg_notify=1 immediately, b_out=0, no m_out_notify; new burst count=1 then completes with m_out=1.
